digit_overlay: RTL and testbench

// Pipelined digit renderer between the VGA timing generator and pixel output.

---
 rtl/digit_overlay_if.sv | 49 ++++
 rtl/digit_overlay.sv | 153 +++++++++++++++
 tb/tb_digit_overlay.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_overlay_if.sv
// ---------------------------------------------------------------------------
// digit_overlay_if
// Bundles the video-timing, digit-load, glyph-ROM and composited-output
// signals of digit_overlay.
//   master : video source / ROM side (drives pixel stream, digits, glyph_data)
//   slave  : digit_overlay (drives glyph address and delayed pixel stream)
// Signals:
//   pixel_x/pixel_y   10  current pixel coordinate
//   de_in/hsync_in/vsync_in  timing in (syncs active-low)
//   bg_in             6   background colour, RGB222
//   digits_in         4*NUM_DIGITS  BCD digits, digit 0 in the top nibble
//   digits_load       1   capture strobe for digits_in
//   glyph_digit/row/col   ROM address (glyph_digit 4'hF = blank)
//   glyph_data        6   ROM colour, combinational from glyph_*
//   pixel_out         6   composited colour
//   de_out/hsync_out/vsync_out  timing aligned with pixel_out
// ---------------------------------------------------------------------------
interface digit_overlay_if #(parameter int NUM_DIGITS = 3);
    logic [9:0]              pixel_x;
    logic [9:0]              pixel_y;
    logic                    de_in;
    logic                    hsync_in;
    logic                    vsync_in;
    logic [5:0]              bg_in;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    digits_load;
    logic [3:0]              glyph_digit;
    logic [4:0]              glyph_row;
    logic [4:0]              glyph_col;
    logic [5:0]              glyph_data;
    logic [5:0]              pixel_out;
    logic                    de_out;
    logic                    hsync_out;
    logic                    vsync_out;

    modport master (
        output pixel_x, pixel_y, de_in, hsync_in, vsync_in, bg_in,
               digits_in, digits_load, glyph_data,
        input  glyph_digit, glyph_row, glyph_col,
               pixel_out, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  pixel_x, pixel_y, de_in, hsync_in, vsync_in, bg_in,
               digits_in, digits_load, glyph_data,
        output glyph_digit, glyph_row, glyph_col,
               pixel_out, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/digit_overlay.sv
// ---------------------------------------------------------------------------
// digit_overlay
// Two-stage pixel pipeline that overlays a row of NUM_DIGITS 8x16 glyphs
// (replicated SCALE times) on the incoming video stream.
//   Stage 1: pixel coordinate -> glyph ROM address (glyph_* outputs).
//   Stage 2: ROM colour composited over the delayed background.
// Digit values are captured into a shadow register on digits_load and copied
// to the displayed set only at the vsync falling edge, so a frame never
// mixes old and new digits.
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high
//   bus    digit_overlay_if.slave (see interface header)
// ---------------------------------------------------------------------------
module digit_overlay #(
    parameter int NUM_DIGITS = 3,
    parameter int ORIGIN_X   = 64,
    parameter int ORIGIN_Y   = 48,
    parameter int SCALE      = 4,   // 1, 2, 4 or 8
    parameter int LZ_BLANK   = 1
) (
    input  logic            clk,
    input  logic            reset,
    digit_overlay_if.slave  bus
);
    localparam int SCALE_SH = $clog2(SCALE);
    localparam int CELL_SH  = SCALE_SH + 3;      // log2 of cell width in pixels
    localparam int IDX_W    = 11 - CELL_SH;
    localparam int BOX_W    = NUM_DIGITS * 8 * SCALE;
    localparam int BOX_H    = 16 * SCALE;
    localparam logic [3:0] BLANK  = 4'hF;
    localparam logic [5:0] TRANSP = 6'h3F;

    // ---------------- digit registers ----------------
    logic [NUM_DIGITS-1:0][3:0] load_src;   // digits_in, re-indexed by position
    logic [NUM_DIGITS-1:0][3:0] frame_src;  // values becoming active this frame
    logic [NUM_DIGITS-1:0][3:0] disp_d;     // frame_src with blanking folded in
    logic [NUM_DIGITS-1:0][3:0] shadow_q;
    logic [NUM_DIGITS-1:0][3:0] active_q;   // already holds BLANK where hidden
    logic                       vs_prev_q;
    logic                       frame_start;
    logic                       leading;

    assign frame_start = vs_prev_q && !bus.vsync_in;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            load_src[i] = bus.digits_in[4*(NUM_DIGITS-1-i) +: 4];
    end

    // A load coinciding with the boundary bypasses the shadow so the new
    // value is visible in the frame that is just starting.
    always_comb begin
        frame_src = bus.digits_load ? load_src : shadow_q;
        leading   = 1'b1;
        disp_d    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (frame_src[i] > 4'd9)
                disp_d[i] = BLANK;
            else if (LZ_BLANK != 0 && leading && frame_src[i] == 4'd0 && i != NUM_DIGITS-1)
                disp_d[i] = BLANK;
            else
                disp_d[i] = frame_src[i];
            if (frame_src[i] != 4'd0)
                leading = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '1;
            active_q  <= '1;
            vs_prev_q <= 1'b1;
        end else begin
            if (bus.digits_load) shadow_q <= load_src;
            if (frame_start)     active_q <= disp_d;
            vs_prev_q <= bus.vsync_in;
        end
    end

    // ---------------- stage 1: address generation ----------------
    logic [10:0] dx, dy;
    logic        in_box;
    logic [3:0]  cell_digit;
    logic        show;
    logic [3:0]  digit_d;
    logic [4:0]  row_d, col_d;

    assign dx = {1'b0, bus.pixel_x} - 11'(ORIGIN_X);
    assign dy = {1'b0, bus.pixel_y} - 11'(ORIGIN_Y);
    assign in_box = ({1'b0, bus.pixel_x} >= 11'(ORIGIN_X)) && (dx < 11'(BOX_W)) &&
                    ({1'b0, bus.pixel_y} >= 11'(ORIGIN_Y)) && (dy < 11'(BOX_H)) &&
                    bus.de_in;

    // Compare-select rather than direct indexing so an out-of-box dx never
    // addresses past the digit array.
    always_comb begin
        cell_digit = BLANK;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (dx[10:CELL_SH] == IDX_W'(i)) cell_digit = active_q[i];
    end

    assign show    = in_box && (cell_digit != BLANK);
    assign digit_d = show ? cell_digit : BLANK;
    assign col_d   = show ? {2'b00, dx[SCALE_SH +: 3]} : 5'd0;
    assign row_d   = show ? {1'b0,  dy[SCALE_SH +: 4]} : 5'd0;

    logic [3:0] glyph_digit_q;
    logic [4:0] glyph_row_q, glyph_col_q;
    logic       in_box_q;
    logic [5:0] bg_q;
    logic [1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;  // [0] stage 1, [1] output

    // ---------------- stage 2: composite ----------------
    logic [5:0] pix_d;
    logic [5:0] pixel_out_q;

    assign pix_d = (in_box_q && glyph_digit_q != BLANK && bus.glyph_data != TRANSP)
                   ? bus.glyph_data
                   : (de_pipe_q[0] ? bg_q : 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            glyph_digit_q <= BLANK;
            glyph_row_q   <= '0;
            glyph_col_q   <= '0;
            in_box_q      <= 1'b0;
            bg_q          <= '0;
            de_pipe_q     <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            pixel_out_q   <= '0;
        end else begin
            glyph_digit_q <= digit_d;
            glyph_row_q   <= row_d;
            glyph_col_q   <= col_d;
            in_box_q      <= in_box;
            bg_q          <= bus.bg_in;
            de_pipe_q     <= {de_pipe_q[0], bus.de_in};
            hs_pipe_q     <= {hs_pipe_q[0], bus.hsync_in};
            vs_pipe_q     <= {vs_pipe_q[0], bus.vsync_in};
            pixel_out_q   <= pix_d;
        end
    end

    assign bus.glyph_digit = glyph_digit_q;
    assign bus.glyph_row   = glyph_row_q;
    assign bus.glyph_col   = glyph_col_q;
    assign bus.pixel_out   = pixel_out_q;
    assign bus.de_out      = de_pipe_q[1];
    assign bus.hsync_out   = hs_pipe_q[1];
    assign bus.vsync_out   = vs_pipe_q[1];
endmodule

// File: tb/tb_digit_overlay.sv
// ---------------------------------------------------------------------------
// tb_digit_overlay
// Directed stimulus for digit_overlay with a reference model that works from
// pixel coordinates by integer division. A compare process checks every
// output each cycle against the model; literal checks in the stimulus pin
// known addresses and colours.
// ---------------------------------------------------------------------------
module tb_digit_overlay;
    localparam int N  = 3;
    localparam int OX = 64;
    localparam int OY = 48;
    localparam int S  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    digit_overlay_if #(.NUM_DIGITS(N)) bus();

    digit_overlay #(
        .NUM_DIGITS(N), .ORIGIN_X(OX), .ORIGIN_Y(OY), .SCALE(S), .LZ_BLANK(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int rom_mode = 0;   // 0 pattern, 1 all black, 2 all transparent

    function automatic logic [5:0] rom(logic [3:0] d, logic [4:0] r, logic [4:0] c, int mode);
        if (mode == 1) return 6'h00;
        if (mode == 2) return 6'h3F;
        return 6'((int'(d) * 11 + int'(r) * 5 + int'(c) * 3) % 64);
    endfunction

    assign bus.glyph_data = rom(bus.glyph_digit, bus.glyph_row, bus.glyph_col, rom_mode);

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  shadow[N];
    int  shown[N];
    bit  prev_vs;
    bit  primed = 1'b0;
    int  e_dig, e_row, e_col, e_bg;
    bit  e_inbox, e_de, e_hs, e_vs;
    int  e_pix;
    bit  e_deo, e_hso, e_vso;

    // Digits left of the most significant nonzero digit are hidden; the last
    // digit is always a candidate; non-BCD codes are hidden.
    function automatic void refresh();
        int first = N - 1;
        for (int i = N - 1; i >= 0; i--)
            if (shadow[i] != 0) first = i;
        for (int i = 0; i < N; i++)
            shown[i] = (i < first || shadow[i] > 9) ? 15 : shadow[i];
    endfunction

    always @(posedge clk) begin : model
        int r, x, y, d;
        bit in;
        if (reset) begin
            e_dig = 15; e_row = 0; e_col = 0; e_bg = 0;
            e_inbox = 0; e_de = 0; e_hs = 1; e_vs = 1;
            e_pix = 0; e_deo = 0; e_hso = 1; e_vso = 1;
            for (int i = 0; i < N; i++) begin shadow[i] = 15; shown[i] = 15; end
            prev_vs = 1;
        end else begin
            r = int'(rom(4'(e_dig), 5'(e_row), 5'(e_col), rom_mode));
            e_pix = (e_inbox && e_dig != 15 && r != 63) ? r : (e_de ? e_bg : 0);
            e_deo = e_de; e_hso = e_hs; e_vso = e_vs;

            x  = int'(bus.pixel_x);
            y  = int'(bus.pixel_y);
            in = bus.de_in && x >= OX && (x - OX) < N * 8 * S && y >= OY && (y - OY) < 16 * S;
            d  = in ? shown[(x - OX) / (8 * S)] : 15;
            if (d != 15) begin
                e_dig = d;
                e_col = ((x - OX) / S) % 8;
                e_row = ((y - OY) / S) % 16;
            end else begin
                e_dig = 15; e_col = 0; e_row = 0;
            end
            e_inbox = in; e_de = bus.de_in; e_hs = bus.hsync_in; e_vs = bus.vsync_in;
            e_bg = int'(bus.bg_in);

            if (bus.digits_load)
                for (int i = 0; i < N; i++) shadow[i] = int'(bus.digits_in[4*(N-1-i) +: 4]);
            if (prev_vs && !bus.vsync_in) refresh();
            prev_vs = bus.vsync_in;
        end
        primed = 1'b1;
    end

    always @(negedge clk) begin
        if (primed) begin
            chk("glyph_digit", int'(bus.glyph_digit), e_dig);
            chk("glyph_row",   int'(bus.glyph_row),   e_row);
            chk("glyph_col",   int'(bus.glyph_col),   e_col);
            chk("pixel_out",   int'(bus.pixel_out),   e_pix);
            chk("de_out",      int'(bus.de_out),      int'(e_deo));
            chk("hsync_out",   int'(bus.hsync_out),   int'(e_hso));
            chk("vsync_out",   int'(bus.vsync_out),   int'(e_vso));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(int x, int y, bit de, bit hs, bit vs, int bg);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.de_in    = de;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.bg_in    = 6'(bg);
        @(negedge clk);
    endtask

    task automatic pix(int x, int y, int bg);
        drive(x, y, 1'b1, 1'b1, 1'b1, bg);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic load(logic [11:0] v);
        bus.digits_in   = v;
        bus.digits_load = 1'b1;
        idle(1);
        bus.digits_load = 1'b0;
    endtask

    // vsync high then falling; optional load on the falling-edge cycle
    task automatic frame(bit with_load, logic [11:0] v);
        idle(1);
        bus.digits_in   = v;
        bus.digits_load = with_load;
        drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
        bus.digits_load = 1'b0;
        drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(1);
    endtask

    task automatic scan();
        for (int y = 40; y < 120; y += 7)
            for (int x = 56; x < 170; x += 3)
                pix(x, y, (x + y) % 64);
        idle(2);
    endtask

    task automatic glyph_at(string name, int x, int y, int dig, int row, int col);
        pix(x, y, 5);
        chk({name, ".digit"}, int'(bus.glyph_digit), dig);
        chk({name, ".row"},   int'(bus.glyph_row),   row);
        chk({name, ".col"},   int'(bus.glyph_col),   col);
    endtask

    initial begin
        reset = 1'b1;
        bus.digits_in   = '0;
        bus.digits_load = 1'b0;
        bus.pixel_x = '0; bus.pixel_y = '0; bus.bg_in = '0;
        bus.de_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.pixel_out",   int'(bus.pixel_out),   0);
        chk("rst.de_out",      int'(bus.de_out),      0);
        chk("rst.hsync_out",   int'(bus.hsync_out),   1);
        chk("rst.vsync_out",   int'(bus.vsync_out),   1);
        chk("rst.glyph_digit", int'(bus.glyph_digit), 15);
        reset = 1'b0;

        // T1: nothing loaded -> background everywhere
        frame(1'b0, 12'h000);
        scan();
        pix(100, 60, 6'h2A); idle(1);
        chk("t1.bg", int'(bus.pixel_out), 6'h2A);

        // T2: 0x123 placement and box edges
        load(12'h123); frame(1'b0, 12'h000);
        glyph_at("t2.a", 64, 48, 1, 0, 0);
        glyph_at("t2.b", 96, 48, 2, 0, 0);
        glyph_at("t2.c", 159, 111, 3, 15, 7);
        glyph_at("t2.left", 63, 48, 15, 0, 0);
        glyph_at("t2.right", 160, 48, 15, 0, 0);
        glyph_at("t2.below", 64, 112, 15, 0, 0);
        scan();

        // T3: leading-zero blanking and non-BCD codes
        load(12'h007); frame(1'b0, 12'h000);
        glyph_at("t3.d0", 64, 48, 15, 0, 0);
        glyph_at("t3.d1", 96, 48, 15, 0, 0);
        glyph_at("t3.d2", 128, 48, 7, 0, 0);
        load(12'h000); frame(1'b0, 12'h000);
        glyph_at("t3.z1", 96, 48, 15, 0, 0);
        glyph_at("t3.z2", 128, 48, 0, 0, 0);
        load(12'h1A3); frame(1'b0, 12'h000);
        glyph_at("t3.bad", 96, 60, 15, 0, 0);
        glyph_at("t3.one", 68, 60, 1, 3, 1);
        scan();

        // T4: mid-frame load waits for the boundary; boundary-cycle load is immediate
        load(12'h123); frame(1'b0, 12'h000);
        load(12'h456);
        glyph_at("t4.old", 64, 48, 1, 0, 0);
        frame(1'b0, 12'h000);
        glyph_at("t4.new", 64, 48, 4, 0, 0);
        frame(1'b1, 12'h789);
        glyph_at("t4.same", 64, 48, 7, 0, 0);
        scan();

        // T5: compositing and sync delay (digit 7 at (64,48): 7*11 = 77 -> 13)
        pix(64, 48, 6'h15); idle(1);
        chk("t5.glyph", int'(bus.pixel_out), 13);
        rom_mode = 1;
        pix(64, 48, 6'h15); idle(1);
        chk("t5.black", int'(bus.pixel_out), 0);
        rom_mode = 2;
        pix(64, 48, 6'h15); idle(1);
        chk("t5.transp", int'(bus.pixel_out), 6'h15);
        rom_mode = 0;
        drive(64, 48, 1'b0, 1'b1, 1'b1, 6'h15); idle(1);
        chk("t5.de0", int'(bus.pixel_out), 0);
        drive(0, 0, 1'b0, 1'b0, 1'b1, 0);
        chk("t5.hs_d1", int'(bus.hsync_out), 1);
        idle(1);
        chk("t5.hs_d2", int'(bus.hsync_out), 0);
        drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
        chk("t5.vs_d1", int'(bus.vsync_out), 1);
        idle(1);
        chk("t5.vs_d2", int'(bus.vsync_out), 0);
        idle(2);

        // T6: reset mid-line flushes pipeline and digits
        pix(70, 50, 9);
        reset = 1'b1;
        pix(72, 50, 9);
        chk("t6.digit", int'(bus.glyph_digit), 15);
        chk("t6.pix",   int'(bus.pixel_out),   0);
        chk("t6.de",    int'(bus.de_out),      0);
        chk("t6.hs",    int'(bus.hsync_out),   1);
        reset = 1'b0;
        glyph_at("t6.blank", 128, 48, 15, 0, 0);
        load(12'h321);
        glyph_at("t6.noframe", 64, 48, 15, 0, 0);
        frame(1'b0, 12'h000);
        glyph_at("t6.back", 64, 48, 3, 0, 0);
        scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
